// File: rtl/gain_offset_clamp_pkg.sv
// gain_offset_clamp_pkg: shared arithmetic helpers for the multi-channel gain/offset/clamp datapath
package gain_offset_clamp_pkg;

    function automatic logic [63:0] unity_gain(input int radix);
        return 64'(1) << radix;
    endfunction

    // Round half toward +inf, then drop the fractional bits
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] value, input int radix);
        return radix == 0 ? value : (value + (64'sd1 <<< (radix - 1))) >>> radix;
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value, input int width,
                                                      output logic clip);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        clip = value > hi || value < lo;
        return value > hi ? hi : value < lo ? lo : value;
    endfunction

endpackage

// File: rtl/goc_gain_ramp.sv
// goc_gain_ramp: per-channel current/target gain registers with bounded-step ramping
module goc_gain_ramp
    import gain_offset_clamp_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CH_W       = 2,
    parameter int GAIN_WIDTH = 16,
    parameter int GAIN_RADIX = 8,
    parameter int GAIN_STEP  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step_en,
    input  logic [CH_W-1:0]       step_chan,
    input  logic                  cfg_wr,
    input  logic [CH_W-1:0]       cfg_chan,
    input  logic [GAIN_WIDTH-1:0] cfg_gain,
    output logic [GAIN_WIDTH-1:0] gain,
    output logic [NCH-1:0]        ramp_active
);

    localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(unity_gain(GAIN_RADIX));
    localparam logic [GAIN_WIDTH-1:0] STEP  = GAIN_WIDTH'(GAIN_STEP);

    logic [GAIN_WIDTH-1:0] cur [NCH];
    logic [GAIN_WIDTH-1:0] tgt [NCH];
    logic [GAIN_WIDTH-1:0] c, t, nxt;

    assign gain = cur[step_chan];

    always_comb begin
        c = cur[step_chan];
        t = tgt[step_chan];
        nxt = GAIN_STEP == 0 ? t
            : t > c ? (t - c > STEP ? c + STEP : t)
            : (c - t > STEP ? c - STEP : t);
        for (int i = 0; i < NCH; i++) ramp_active[i] = cur[i] != tgt[i];
    end

    always_ff @(posedge clk)
        if (reset) begin
            cur <= '{default: UNITY};
            tgt <= '{default: UNITY};
        end else begin
            if (step_en) cur[step_chan] <= nxt;
            if (cfg_wr) tgt[cfg_chan] <= cfg_gain;
        end

endmodule

// File: rtl/gain_offset_clamp_ramp.sv
// gain_offset_clamp_ramp: time-shared multi-channel gain/offset/clamp pipeline with ramped gain changes
module gain_offset_clamp_ramp
    import gain_offset_clamp_pkg::*;
#(
    parameter int NCH          = 4,
    parameter int IN_WIDTH     = 8,
    parameter int GAIN_WIDTH   = 16,
    parameter int GAIN_RADIX   = 8,
    parameter int OFFSET_WIDTH = 8,
    parameter int OUT_WIDTH    = 8,
    parameter int GAIN_STEP    = 0,
    localparam int CH_W        = NCH > 1 ? $clog2(NCH) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic signed [IN_WIDTH-1:0]     in,
    input  logic                           in_valid,
    input  logic [CH_W-1:0]                in_chan,
    input  logic                           cfg_wr,
    input  logic [CH_W-1:0]                cfg_chan,
    input  logic [GAIN_WIDTH-1:0]          cfg_gain,
    input  logic signed [OFFSET_WIDTH-1:0] cfg_offset,
    input  logic                           clip_clear,
    output logic signed [OUT_WIDTH-1:0]    out,
    output logic                           out_valid,
    output logic [CH_W-1:0]                out_chan,
    output logic                           out_clip,
    output logic [NCH-1:0]                 clip_status,
    output logic [NCH-1:0]                 ramp_active
);

    localparam int PW = IN_WIDTH + GAIN_WIDTH + 1;
    localparam int SW = (PW > OFFSET_WIDTH ? PW : OFFSET_WIDTH) + 1;

    logic                           in_ok, cfg_en;
    logic [GAIN_WIDTH-1:0]          gain;
    logic signed [OFFSET_WIDTH-1:0] offset [NCH];
    logic                           s1_v, s2_v;
    logic [CH_W-1:0]                s1_ch, s2_ch;
    logic signed [PW-1:0]           s1_prod;
    logic signed [OFFSET_WIDTH-1:0] s1_off;
    logic signed [SW-1:0]           s2_sum;
    logic signed [OUT_WIDTH-1:0]    sat_val;
    logic                           sat_clip;

    // A channel index outside 0..NCH-1 only exists when NCH is not a power of two
    if (NCH == (1 << CH_W)) begin : g_full
        assign in_ok  = in_valid;
        assign cfg_en = cfg_wr;
    end else begin : g_part
        assign in_ok  = in_valid && in_chan < CH_W'(NCH);
        assign cfg_en = cfg_wr && cfg_chan < CH_W'(NCH);
    end

    goc_gain_ramp #(
        .NCH(NCH), .CH_W(CH_W), .GAIN_WIDTH(GAIN_WIDTH), .GAIN_RADIX(GAIN_RADIX), .GAIN_STEP(GAIN_STEP)
    ) u_ramp (
        .clk(clk), .reset(reset), .step_en(in_ok), .step_chan(in_chan),
        .cfg_wr(cfg_en), .cfg_chan(cfg_chan), .cfg_gain(cfg_gain),
        .gain(gain), .ramp_active(ramp_active)
    );

    always_comb begin
        sat_clip = 1'b0;
        sat_val = OUT_WIDTH'(sat_signed(64'(s2_sum), OUT_WIDTH, sat_clip));
    end

    always_ff @(posedge clk)
        if (reset) begin
            offset <= '{default: '0};
            {s1_v, s2_v, out_valid, out_clip} <= '0;
            out <= '0;
            out_chan <= '0;
            clip_status <= '0;
        end else begin
            s1_v <= in_ok;
            s2_v <= s1_v;
            out_valid <= s2_v;
            if (in_ok) begin
                s1_ch <= in_chan;
                s1_prod <= PW'(in) * PW'($signed({1'b0, gain}));
                s1_off <= offset[in_chan];
            end
            if (s1_v) begin
                s2_ch <= s1_ch;
                s2_sum <= SW'(round_shift(64'(s1_prod), GAIN_RADIX)) + SW'(s1_off);
            end
            if (s2_v) begin
                out <= sat_val;
                out_chan <= s2_ch;
                out_clip <= sat_clip;
            end
            if (cfg_en) offset[cfg_chan] <= cfg_offset;
            clip_status <= (clip_clear ? '0 : clip_status) | (s2_v && sat_clip ? NCH'(1) << s2_ch : '0);
        end

endmodule

// File: tb/tb_gain_offset_clamp_ramp.sv
// tb_gain_offset_clamp_ramp: immediate-gain and ramped-gain instances checked against an arithmetic reference model
module tb_gain_offset_clamp_ramp;

    localparam int NCH = 6;
    localparam int STEPS [2] = '{0, 64};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic signed [7:0] in = '0;
    logic              in_valid = 1'b0;
    logic [2:0]        in_chan = '0;
    logic              cfg_wr = 1'b0;
    logic [2:0]        cfg_chan = '0;
    logic [15:0]       cfg_gain = '0;
    logic signed [7:0] cfg_offset = '0;
    logic              clip_clear = 1'b0;

    logic signed [7:0] out_o [2];
    logic              out_valid_o [2];
    logic [2:0]        out_chan_o [2];
    logic              out_clip_o [2];
    logic [NCH-1:0]    clip_o [2];
    logic [NCH-1:0]    ramp_o [2];

    always #5 clk = ~clk;

    gain_offset_clamp_ramp #(.NCH(NCH)) u_imm (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_chan(in_chan),
        .cfg_wr(cfg_wr), .cfg_chan(cfg_chan), .cfg_gain(cfg_gain), .cfg_offset(cfg_offset),
        .clip_clear(clip_clear), .out(out_o[0]), .out_valid(out_valid_o[0]), .out_chan(out_chan_o[0]),
        .out_clip(out_clip_o[0]), .clip_status(clip_o[0]), .ramp_active(ramp_o[0])
    );

    gain_offset_clamp_ramp #(.NCH(NCH), .GAIN_STEP(64)) u_ramp (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_chan(in_chan),
        .cfg_wr(cfg_wr), .cfg_chan(cfg_chan), .cfg_gain(cfg_gain), .cfg_offset(cfg_offset),
        .clip_clear(clip_clear), .out(out_o[1]), .out_valid(out_valid_o[1]), .out_chan(out_chan_o[1]),
        .out_clip(out_clip_o[1]), .clip_status(clip_o[1]), .ramp_active(ramp_o[1])
    );

    typedef struct packed {
        logic             v;
        logic             rst;
        logic [2:0]       ch;
        logic [1:0]       clip;
        logic [1:0][31:0] val;
    } exp_t;

    int   total = 0, bad = 0;
    int   cur [2][NCH];
    int   tgt [2][NCH];
    int   off [NCH];
    bit   flag [2][NCH];
    bit   pend_clr = 1'b0, armed = 1'b0;
    exp_t q [$];
    int   s_rst = 0, s_v = 0, s_ch = 0, s_x = 0, s_wr = 0, s_cch = 0, s_g = 0, s_o = 0, s_clr = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_out(input int x, input int g, input int o, output bit clip);
        longint t, s;
        t = longint'(x) * g + 128;
        s = (t >= 0 ? t / 256 : -((-t + 255) / 256)) + o;
        clip = s > 127 || s < -128;
        return int'(s > 127 ? 127 : s < -128 ? -128 : s);
    endfunction

    function automatic int approach(input int c, input int t, input int st);
        if (st == 0 || (t - c <= st && c - t <= st)) return t;
        return t > c ? c + st : c - st;
    endfunction

    task automatic observe();
        exp_t e;
        logic [NCH-1:0] ef, er;
        string n;
        e = q.pop_front();
        if (pend_clr) foreach (flag[i, c]) flag[i][c] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n = i ? "ramp" : "imm";
            if (e.v && e.clip[i]) flag[i][e.ch] = 1'b1;
            check({n, ".out_valid"}, out_valid_o[i], e.v);
            if (e.v) begin
                check({n, ".out_chan"}, out_chan_o[i], e.ch);
                check({n, ".out"}, out_o[i], $signed(e.val[i]));
                check({n, ".out_clip"}, out_clip_o[i], e.clip[i]);
            end
            if (e.rst) begin
                check({n, ".rst_out"}, out_o[i], 0);
                check({n, ".rst_chan"}, out_chan_o[i], 0);
                check({n, ".rst_clip"}, out_clip_o[i], 0);
            end
            for (int c = 0; c < NCH; c++) begin
                ef[c] = flag[i][c];
                er[c] = cur[i][c] != tgt[i][c];
            end
            check({n, ".clip_status"}, clip_o[i], ef);
            check({n, ".ramp_active"}, ramp_o[i], er);
        end
    endtask

    task automatic model();
        exp_t e;
        bit   cl;
        e = '0;
        if (s_rst != 0) begin
            armed = 1'b1;
            pend_clr = 1'b0;
            q.delete();
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < NCH; c++) begin
                    cur[i][c] = 256;
                    tgt[i][c] = 256;
                    flag[i][c] = 1'b0;
                    off[c] = 0;
                end
            e.rst = 1'b1;
            q.push_back(e);
            e.rst = 1'b0;
            q.push_back(e);
            q.push_back(e);
        end else begin
            pend_clr = s_clr != 0;
            if (s_v != 0 && s_ch < NCH) begin
                e.v = 1'b1;
                e.ch = 3'(s_ch);
                for (int i = 0; i < 2; i++) begin
                    e.val[i] = ref_out(s_x, cur[i][s_ch], off[s_ch], cl);
                    e.clip[i] = cl;
                    cur[i][s_ch] = approach(cur[i][s_ch], tgt[i][s_ch], STEPS[i]);
                end
            end
            if (s_wr != 0 && s_cch < NCH) begin
                tgt[0][s_cch] = s_g;
                tgt[1][s_cch] = s_g;
                off[s_cch] = s_o;
            end
            q.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (armed) observe();
        reset = s_rst != 0;
        in_valid = s_v != 0;
        in_chan = 3'(s_ch);
        in = 8'(s_x);
        cfg_wr = s_wr != 0;
        cfg_chan = 3'(s_cch);
        cfg_gain = 16'(s_g);
        cfg_offset = 8'(s_o);
        clip_clear = s_clr != 0;
        model();
        {s_rst, s_v, s_ch, s_x, s_wr, s_cch, s_g, s_o, s_clr} = '0;
    endtask

    task automatic samp(input int ch, input int x);
        s_v = 1;
        s_ch = ch;
        s_x = x;
        step();
    endtask

    task automatic cfg(input int ch, input int g, input int o);
        s_wr = 1;
        s_cch = ch;
        s_g = g;
        s_o = o;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    initial begin
        s_rst = 1;
        step();
        s_rst = 1;
        step();
        idle(2);
        samp(0, 50);
        samp(0, -7);
        idle(4);
        cfg(1, 512, 0);
        samp(1, 50);
        samp(1, 100);
        samp(1, -100);
        idle(4);
        s_clr = 1;
        step();
        idle(2);
        samp(1, 100);
        step();
        s_clr = 1;
        step();
        idle(3);
        cfg(2, 384, 0);
        samp(2, 3);
        samp(2, -3);
        cfg(3, 256, -10);
        samp(3, 5);
        idle(4);
        cfg(0, 512, 0);
        repeat (6) samp(0, 10);
        idle(4);
        cfg(1, 300, 5);
        cfg(2, 128, -3);
        cfg(3, 700, 20);
        for (int c = 0; c < 4; c++) samp(c, 40);
        s_v = 1; s_ch = 2; s_x = 60; s_wr = 1; s_cch = 2; s_g = 1000; s_o = 50;
        step();
        samp(2, 60);
        samp(6, 10);
        samp(7, 10);
        idle(4);
        samp(0, 10);
        samp(1, 20);
        s_rst = 1;
        step();
        idle(4);
        samp(1, 50);
        idle(4);
        for (int k = 0; k < 3000; k++) begin
            s_v = int'($urandom_range(3) != 0);
            s_ch = int'($urandom_range(7));
            s_x = int'($urandom_range(255)) - 128;
            s_wr = int'($urandom_range(7) == 0);
            s_cch = int'($urandom_range(7));
            s_g = $urandom_range(3) == 0 ? int'($urandom_range(65535)) : int'($urandom_range(1023));
            s_o = int'($urandom_range(255)) - 128;
            s_clr = int'($urandom_range(15) == 0);
            s_rst = int'($urandom_range(499) == 0);
            step();
        end
        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
